// File: rtl/adc_avg_fifo.sv
// SAR ADC sequencer that averages 1/2/4/8 samples per result
// and buffers the results in a first-word-fall-through FIFO.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   en, trig, cont      enable, single-shot request, continuous mode
//   avg_sel             samples per result: 2^avg_sel
//   soc, eoc_in         start / end of conversion to/from SAR
//   data_in             SAR result, valid while eoc_in is high
//   rd, rd_data         FIFO pop and FIFO head
//   empty, full, level  FIFO status
//   thresh, thresh_hit  level threshold and its flag
//   ovf, ovf_clr        sticky overflow flag and its clear
//   busy                sequencer not idle
module adc_avg_fifo #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          trig,
  input  logic          cont,
  input  logic [1:0]    avg_sel,
  output logic          soc,
  input  logic          eoc_in,
  input  logic [SIZE-1:0] data_in,
  input  logic          rd,
  output logic [SIZE-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level,
  input  logic [AW:0]   thresh,
  output logic          thresh_hit,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    PUSH  = 2'd3
  } state_t;

  state_t          state;
  logic [1:0]      n_sel;
  logic [SIZE+2:0] acc;
  logic [2:0]      cnt;
  logic            last;
  logic [SIZE-1:0] result;

  logic [SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            push;
  logic            wr_en;
  logic            rd_en;
  logic            ovf_set;

  // Widened compare so 8 samples (cnt wraps to 0) is detected.
  assign last = (({1'b0, cnt} + 4'd1) == (4'd1 << n_sel));

  // Truncating divide by 2^n_sel; the sum of 2^n samples
  // always fits in SIZE bits after the shift.
  always_comb begin
    result = acc[SIZE-1:0];
    unique case (n_sel)
      2'd0: result = acc[SIZE-1:0];
      2'd1: result = acc[SIZE:1];
      2'd2: result = acc[SIZE+1:2];
      2'd3: result = acc[SIZE+2:3];
      default: result = acc[SIZE-1:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      soc   <= 1'b0;
      busy  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      n_sel <= '0;
    end else if (!en) begin
      state <= IDLE;
      soc   <= 1'b0;
      busy  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      soc <= 1'b0;
      unique case (state)
        IDLE: begin
          if (trig || cont) begin
            state <= START;
            soc   <= 1'b1;
            busy  <= 1'b1;
            n_sel <= avg_sel;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        START: begin
          state <= WAIT;
        end
        WAIT: begin
          if (eoc_in) begin
            acc <= acc + {3'b000, data_in};
            cnt <= cnt + 3'd1;
            if (last) begin
              state <= PUSH;
            end else begin
              state <= START;
              soc   <= 1'b1;
            end
          end
        end
        PUSH: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign push    = (state == PUSH);
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot a full push needs.
  assign wr_en   = push && (!full || rd);
  assign rd_en   = rd && !empty;
  assign ovf_set = push && full && !rd;
  assign rd_data = mem[rd_ptr];

  assign thresh_hit = (thresh != '0) && (level >= thresh);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({wr_en, rd_en})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (ovf_set) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_avg_fifo.sv
// Scoreboard bench for adc_avg_fifo with a SAR responder,
// a queue-based FIFO model and a read-side monitor.
module tb_adc_avg_fifo;

  localparam int SIZE  = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            trig;
  logic            cont;
  logic [1:0]      avg_sel;
  logic            soc;
  logic            eoc_in;
  logic [SIZE-1:0] data_in;
  logic            rd;
  logic [SIZE-1:0] rd_data;
  logic            empty;
  logic            full;
  logic [AW:0]     level;
  logic [AW:0]     thresh;
  logic            thresh_hit;
  logic            ovf;
  logic            ovf_clr;
  logic            busy;

  logic            eoc_r = 1'b0;
  logic [SIZE-1:0] data_r = '0;
  logic            rd_s = 1'b0;
  logic            rd_p = 1'b0;

  assign eoc_in  = eoc_r;
  assign data_in = data_r;
  assign rd      = rd_s | rd_p;

  int checks   = 0;
  int failures = 0;
  int soc_cnt  = 0;
  int fix_dly  = 0;
  int need     = 1;
  bit push_rd  = 1'b0;
  bit model_ovf = 1'b0;

  logic [SIZE-1:0] sb[$];
  logic [SIZE-1:0] samples[$];
  logic [SIZE-1:0] plan[$];

  adc_avg_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .trig(trig),
    .cont(cont), .avg_sel(avg_sel), .soc(soc),
    .eoc_in(eoc_in), .data_in(data_in), .rd(rd),
    .rd_data(rd_data), .empty(empty), .full(full),
    .level(level), .thresh(thresh),
    .thresh_hit(thresh_hit), .ovf(ovf),
    .ovf_clr(ovf_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // SAR responder: answers each soc after a delay.
  initial begin
    int k;
    logic [SIZE-1:0] d;
    forever begin
      @(negedge clk);
      if (soc) begin
        k = (fix_dly != 0) ? fix_dly : $urandom_range(1, 3);
        d = (plan.size() > 0) ? plan.pop_front()
                              : SIZE'($urandom);
        repeat (k) @(posedge clk);
        #1;
        eoc_r = 1'b1;
        data_r = d;
        samples.push_back(d);
        @(posedge clk);
        #1;
        eoc_r = 1'b0;
        data_r = SIZE'($urandom);
        if (push_rd && samples.size() == need) begin
          rd_p = 1'b1;
          @(posedge clk);
          #1;
          rd_p = 1'b0;
        end
      end
    end
  end

  // Monitor: counts soc pulses and checks every pop.
  initial begin
    logic [SIZE-1:0] e;
    forever begin
      @(negedge clk);
      if (soc) soc_cnt++;
      if (rd && !rst && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_data", int'(rd_data), int'(e));
      end
    end
  end

  task automatic check_status(string t);
    int hit;
    hit = (thresh != 0 && sb.size() >= thresh) ? 1 : 0;
    chk({t, ":level"}, int'(level), sb.size());
    chk({t, ":empty"}, int'(empty), sb.size() == 0);
    chk({t, ":full"}, int'(full), sb.size() == DEPTH);
    chk({t, ":thresh_hit"}, int'(thresh_hit), hit);
    chk({t, ":ovf"}, int'(ovf), int'(model_ovf));
    chk({t, ":busy"}, int'(busy), 0);
    chk({t, ":soc"}, int'(soc), 0);
  endtask

  task automatic wait_done(string t);
    int n = 0;
    while (!busy && n < 50) begin step(); n++; end
    while (busy && n < 1000) begin step(); n++; end
    if (n >= 50 && busy) chk({t, ":timeout"}, 1, 0);
    else if (n >= 1000) chk({t, ":timeout"}, 1, 0);
  endtask

  task automatic model_push(int sel);
    int sum = 0;
    chk("samples_per_group", samples.size(), 1 << sel);
    while (samples.size() > 0) sum += int'(samples.pop_front());
    if (sb.size() < DEPTH) sb.push_back(SIZE'(sum >> sel));
    else model_ovf = 1'b1;
  endtask

  task automatic run_group(string t, int sel);
    int s0;
    need = 1 << sel;
    s0 = soc_cnt;
    avg_sel = 2'(sel);
    trig = 1'b1;
    step();
    trig = 1'b0;
    wait_done(t);
    chk({t, ":soc_pulses"}, soc_cnt - s0, 1 << sel);
    model_push(sel);
    check_status(t);
  endtask

  task automatic pop_n(int n);
    for (int i = 0; i < n; i++) begin
      rd_s = 1'b1;
      step();
    end
    rd_s = 1'b0;
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    model_ovf = 1'b0;
  endtask

  initial begin
    int s0;
    int n;
    rst = 1'b1; en = 1'b1; trig = 1'b0; cont = 1'b0;
    avg_sel = 2'd0; ovf_clr = 1'b0; thresh = 5'd3;
    repeat (3) step();
    rst = 1'b0;
    check_status("reset");

    // single sample, rd in PUSH on empty FIFO is ignored
    fix_dly = 2; push_rd = 1'b1;
    plan.push_back(8'hA5);
    run_group("t039", 0);
    chk("t039:rd_data", int'(rd_data), 8'hA5);
    push_rd = 1'b0; fix_dly = 0;

    plan = '{8'h10, 8'h11, 8'h12, 8'h13};
    run_group("t040", 2);
    for (int i = 0; i < 8; i++) plan.push_back(8'hFF);
    run_group("t041", 3);
    pop_n(3);
    check_status("drain1");

    // continuous fill to overflow
    thresh = 5'd16;
    avg_sel = 2'd0;
    cont = 1'b1;
    for (int g = 0; g < 17; g++) begin
      wait_done("cont");
      if (g == 16) cont = 1'b0;
      model_push(0);
      check_status("cont");
    end
    step();
    check_status("cont_end");
    clear_ovf();
    check_status("ovf_clr");

    // full FIFO with pop in the PUSH cycle
    push_rd = 1'b1;
    run_group("t043", 0);
    push_rd = 1'b0;

    // drop with ovf_clr held: set wins
    ovf_clr = 1'b1;
    run_group("setwins", 0);
    ovf_clr = 1'b0;
    step();
    check_status("setwins2");
    clear_ovf();
    pop_n(16);
    check_status("drain2");
    pop_n(2);
    check_status("rd_empty");

    // abort in WAIT after two of four samples
    thresh = 5'd4;
    fix_dly = 3;
    s0 = soc_cnt;
    avg_sel = 2'd2;
    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    while ((soc_cnt - s0) < 3 && n < 200) begin step(); n++; end
    chk("abort:reach_wait", int'(n < 200), 1);
    en = 1'b0;
    step();
    chk("abort:busy", int'(busy), 0);
    step();
    en = 1'b1;
    repeat (6) step();
    samples.delete();
    check_status("abort");
    fix_dly = 0;
    run_group("t044a", 2);
    run_group("t044b", $urandom_range(0, 3));
    run_group("t044c", $urandom_range(0, 3));
    run_group("t044d", $urandom_range(0, 3));
    pop_n(4);

    // randomized groups and pops
    for (int g = 0; g < 24; g++) begin
      thresh = 5'($urandom_range(0, 16));
      run_group("rand", $urandom_range(0, 3));
      pop_n($urandom_range(0, 2));
      check_status("rand_pop");
    end

    // reset mid-conversion discards everything
    if (sb.size() == 0) run_group("prefill", 0);
    s0 = soc_cnt;
    avg_sel = 2'd3;
    trig = 1'b1;
    step();
    trig = 1'b0;
    n = 0;
    while ((soc_cnt - s0) < 4 && n < 200) begin step(); n++; end
    chk("rst_mid:reach", int'(n < 200), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    model_ovf = 1'b0;
    repeat (6) step();
    samples.delete();
    check_status("rst_mid");
    run_group("post_rst", 1);
    pop_n(1);
    check_status("final");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
